// File: rtl/fifo_wr_arbiter_ctrl.sv
// FIFO write-port arbiter and pointer control.
// Round-robin sharing of one write port, status flags, RAM strobes.
module fifo_wr_arbiter_ctrl #(
  parameter int A_LENGTH = 3,
  parameter int DATA_W   = 8
) (
  input  logic                arb_clk,
  input  logic                arb_reset,
  input  logic                wr_req0,
  input  logic [DATA_W-1:0]   wr_data0,
  input  logic                wr_req1,
  input  logic [DATA_W-1:0]   wr_data1,
  output logic                wr_gnt0,
  output logic                wr_gnt1,
  input  logic                rd_req,
  output logic                rd_valid,
  output logic                mem_wr_en,
  output logic [A_LENGTH-1:0] mem_wr_addr,
  output logic [DATA_W-1:0]   mem_wr_data,
  output logic                mem_rd_en,
  output logic [A_LENGTH-1:0] mem_rd_addr,
  output logic                fifo_full,
  output logic                fifo_empty,
  output logic [A_LENGTH:0]   fifo_count,
  output logic                rd_underflow
);

  logic [A_LENGTH:0] wr_ptr_q, wr_ptr_d;
  logic [A_LENGTH:0] rd_ptr_q, rd_ptr_d;
  logic              rr_pri_q, rr_pri_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_underflow_q, rd_underflow_d;
  logic              empty, full;
  logic              gnt0, gnt1;
  logic              rd_accept;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[A_LENGTH] != rd_ptr_q[A_LENGTH]) &&
                 (wr_ptr_q[A_LENGTH-1:0] == rd_ptr_q[A_LENGTH-1:0]);

  // Grant: blocked when full or in reset, rr_pri breaks ties
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!arb_reset && !full) begin
      if (wr_req0 && wr_req1) begin
        gnt0 = ~rr_pri_q;
        gnt1 = rr_pri_q;
      end else begin
        gnt0 = wr_req0;
        gnt1 = wr_req1;
      end
    end
  end

  assign rd_accept = rd_req & ~empty & ~arb_reset;

  // Next-state for pointers, priority, read-valid and underflow
  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    rr_pri_d       = rr_pri_q;
    rd_valid_d     = rd_accept;
    rd_underflow_d = rd_underflow_q | (rd_req & empty);
    if (gnt0 || gnt1) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      rr_pri_d = gnt0;
    end
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge arb_clk) begin
    if (arb_reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      rr_pri_q       <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_underflow_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      rr_pri_q       <= rr_pri_d;
      rd_valid_q     <= rd_valid_d;
      rd_underflow_q <= rd_underflow_d;
    end
  end

  // Write data follows the granted writer, zero when idle
  always_comb begin
    mem_wr_data = '0;
    if (gnt0) begin
      mem_wr_data = wr_data0;
    end else if (gnt1) begin
      mem_wr_data = wr_data1;
    end
  end

  assign wr_gnt0      = gnt0;
  assign wr_gnt1      = gnt1;
  assign mem_wr_en    = gnt0 | gnt1;
  assign mem_wr_addr  = wr_ptr_q[A_LENGTH-1:0];
  assign mem_rd_en    = rd_accept;
  assign mem_rd_addr  = rd_ptr_q[A_LENGTH-1:0];
  assign rd_valid     = rd_valid_q;
  assign rd_underflow = rd_underflow_q;
  assign fifo_full    = full;
  assign fifo_empty   = empty;
  assign fifo_count   = wr_ptr_q - rd_ptr_q;

endmodule

// File: doc/fifo_wr_arbiter_ctrl.md
Name: fifo_wr_arbiter_ctrl

Overview:
- Control block for the single-clock FIFO. Shares the one FIFO write port between two writers using round-robin arbitration.
- Owns the write and read pointers (binary up-counters, A_LENGTH+1 bits including a wrap bit).
- Drives the dual-port memory's enables and addresses, and produces the full/empty/count status.
- Sits between the requesters and the FIFO RAM; the RAM itself is external.

Parameters:
- A_LENGTH, 3, address width. Depth = 2^A_LENGTH (8 entries). Pointers are A_LENGTH+1 bits.
- DATA_W, 8, width of the write data path.

Ports:
- arb_clk  in  1  single clock; all state changes on rising edge.
- arb_reset  in  1  reset, synchronous, active-high.
- wr_req0  in  1  writer 0 request (level, held until granted).
- wr_data0  in  DATA_W  writer 0 data.
- wr_req1  in  1  writer 1 request.
- wr_data1  in  DATA_W  writer 1 data.
- wr_gnt0  out  1  writer 0 granted; write occurs on this edge.
- wr_gnt1  out  1  writer 1 granted.
- rd_req  in  1  reader request.
- rd_valid  out  1  registered; RAM read data valid this cycle.
- mem_wr_en  out  1  RAM write enable.
- mem_wr_addr  out  A_LENGTH  RAM write address.
- mem_wr_data  out  DATA_W  muxed data of the granted writer.
- mem_rd_en  out  1  RAM read enable.
- mem_rd_addr  out  A_LENGTH  RAM read address.
- fifo_full  out  1  FIFO full.
- fifo_empty  out  1  FIFO empty.
- fifo_count  out  A_LENGTH+1  occupancy, 0..2^A_LENGTH.
- rd_underflow  out  1  sticky error flag.

Behaviour:
- Reset (arb_reset=1 at an edge):
  - wr_ptr=0, rd_ptr=0, rr_pri=0, rd_valid=0, rd_underflow=0.
  - Giving: fifo_empty=1, fifo_full=0, fifo_count=0.
  - While arb_reset is high, wr_gnt0/1, mem_wr_en and mem_rd_en are forced to 0.
  - Reset mid-operation discards contents and any in-flight read; rd_valid=0 the cycle after.
- Status (combinational from registered pointers):
  - empty = (wr_ptr == rd_ptr).
  - full = (wr_ptr[A_LENGTH] != rd_ptr[A_LENGTH]) and the lower A_LENGTH bits are equal.
  - count = wr_ptr - rd_ptr, modulo 2^(A_LENGTH+1).
- Arbitration (combinational grant, registered priority):
  - If full, no grant.
  - Else if exactly one request is active, that writer is granted.
  - Else if both are active, writer rr_pri is granted.
  - After any grant, rr_pri <= index of the non-granted writer (toggle to the other). With no grant, rr_pri holds.
  - At most one grant per cycle; gnt0 and gnt1 are never both 1.
- Write:
  - mem_wr_en = gnt0|gnt1.
  - mem_wr_addr = wr_ptr[A_LENGTH-1:0].
  - mem_wr_data = granted writer's data; 0 when no grant.
  - wr_ptr += 1 on grant. Wraps naturally: the MSB toggles every 2^A_LENGTH writes.
- Read:
  - rd_accept = rd_req & !empty.
  - mem_rd_en = rd_accept; mem_rd_addr = rd_ptr[A_LENGTH-1:0].
  - rd_ptr += 1 on accept.
  - rd_valid <= rd_accept: 1-cycle latency, matching a synchronous-read RAM.
- Underflow: rd_req & empty sets rd_underflow (sticky until reset); pointers do not change.
- Simultaneous events use flag values from the start of the cycle:
  - Full plus rd_req: the read proceeds and the write is blocked this cycle. The writer retries and is granted next cycle.
  - Empty plus a write request: the write proceeds and rd_req is refused (underflow flagged). Read data is never bypassed.
  - Neither full nor empty, with both a write and a read: both pointers advance, count unchanged.
- Requests not granted get no acknowledgement; requesters keep req and data stable until granted.

Test Plan:
- Reset then idle → fifo_empty=1, fifo_full=0, fifo_count=0, all grants/enables 0, rd_valid=0.
- wr_req0=wr_req1=1 for 8 cycles from reset, data0=0xA0+n, data1=0xB0+n → grants alternate 0,1,0,1…; addrs 0..7; count=8, fifo_full=1; 9th cycle no grant.
- At full, rd_req=1 and wr_req0=1 same cycle → mem_rd_en=1 with addr 0 and wr_gnt0=0. Next cycle: wr_gnt0=1, mem_wr_addr=0, count stays 8; rd_valid=1 one cycle after the read.
- 20 writes interleaved with 20 reads at count≈4 → both pointers wrap past 15→0, mem addrs wrap 7→0, full/empty never falsely asserted, read order matches write order.
- rd_req=1 while empty → mem_rd_en=0, rd_ptr unchanged, rd_underflow=1 and stays 1 until arb_reset.
- count=5 with both writers requesting, assert arb_reset for 1 cycle → next cycle count=0, fifo_empty=1, rd_valid=0, rr_pri=0 (writer 0 granted first when both request after reset).
